// File: rtl/multi_clk_div_if.sv
// Control and status bundle for multi_clk_div: channel enables, phase
// sync, the divisor write handshake and the divided clock/tick outputs.
interface multi_clk_div_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] En;
  logic              Sync;
  logic              WrEn;
  logic [CH_W-1:0]   WrCh;
  logic [CNT_W-1:0]  WrHalf;
  logic              WrRdy;
  logic [NUM_CH-1:0] ClkOut;
  logic [NUM_CH-1:0] Tick;

  // Controller side: drives enables, sync and write requests.
  modport master (
    output En, Sync, WrEn, WrCh, WrHalf,
    input  WrRdy, ClkOut, Tick
  );

  // Divider side.
  modport slave (
    input  En, Sync, WrEn, WrCh, WrHalf,
    output WrRdy, ClkOut, Tick
  );
endinterface

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider. Each channel toggles ClkOut
// every Half[i] cycles. A single pending-write slot updates one channel's
// half-period; the update lands on a falling ClkOut edge so no short
// pulse is produced, or at once when the channel is idle or Sync is high.
module multi_clk_div #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 26,
  parameter int DEF_HALF = 50000000
) (
  input logic          Clk,
  input logic          Rst_n,
  multi_clk_div_if.slave bus
);
  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0]  HALF_RST = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  half_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;

  logic              pend_vld_q, pend_vld_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]  pend_half_q, pend_half_d;

  logic              wr_acc;
  logic [NUM_CH-1:0] pend_hit;
  logic [NUM_CH-1:0] wr_hit;

  // Decode which channel the pending slot or an incoming write targets.
  always_comb begin
    wr_acc = bus.WrEn && !pend_vld_q && ({1'b0, bus.WrCh} < CH_LIMIT);
    for (int i = 0; i < NUM_CH; i++) begin
      pend_hit[i] = pend_vld_q && (pend_ch_q == CH_W'(i));
      wr_hit[i]   = wr_acc && (bus.WrCh == CH_W'(i));
    end
  end

  // Next-state logic for all channels and the shared write slot.
  always_comb begin
    // NOTE: every target gets a default before any branch, so no path can
    // leave a variable unassigned and infer a latch.
    cnt_d       = cnt_q;
    half_d      = half_q;
    clk_d       = clk_q;
    tick_d      = '0;
    pend_vld_d  = pend_vld_q;
    pend_ch_d   = pend_ch_q;
    pend_half_d = pend_half_q;

    if (bus.Sync) begin
      // Phase-align restart; a pending or simultaneous write lands now.
      pend_vld_d = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_d[i] = '0;
        clk_d[i] = 1'b0;
        if (pend_hit[i])    half_d[i] = pend_half_q;
        else if (wr_hit[i]) half_d[i] = bus.WrHalf;
      end
    end else begin
      if (wr_acc) begin
        pend_vld_d  = 1'b1;
        pend_ch_d   = bus.WrCh;
        pend_half_d = bus.WrHalf;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (pend_hit[i] && (!bus.En[i] || half_q[i] == '0)) begin
          // Idle channel: nothing to glitch, apply immediately.
          half_d[i]  = pend_half_q;
          cnt_d[i]   = '0;
          clk_d[i]   = 1'b0;
          pend_vld_d = 1'b0;
        end else if (half_q[i] == '0) begin
          cnt_d[i] = '0;
          clk_d[i] = 1'b0;
        end else if (bus.En[i]) begin
          // half_q >= 1 here, so the decrement cannot wrap.
          if (cnt_q[i] == half_q[i] - ONE) begin
            cnt_d[i]  = '0;
            clk_d[i]  = ~clk_q[i];
            tick_d[i] = ~clk_q[i];
            if (pend_hit[i] && clk_q[i]) begin
              half_d[i]  = pend_half_q;
              pend_vld_d = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      // NOTE: the half-period array is a handful of flops, not a RAM, so it
      // is reset like any other register to restore the default rate.
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        half_q[i] <= HALF_RST;
      end
      clk_q       <= '0;
      tick_q      <= '0;
      pend_vld_q  <= 1'b0;
      pend_ch_q   <= '0;
      pend_half_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
      pend_vld_q  <= pend_vld_d;
      pend_ch_q   <= pend_ch_d;
      pend_half_q <= pend_half_d;
    end
  end

  assign bus.ClkOut = clk_q;
  assign bus.Tick   = tick_q;
  assign bus.WrRdy  = ~pend_vld_q;

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels.
REQ-002 SHALL have parameter CNT_W, default 26, width of each half-period counter and divisor.
REQ-003 SHALL have parameter DEF_HALF, default 50000000, reset half-period of every channel (1 Hz from 100 MHz).
REQ-004 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port En  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port Sync  input  1  phase-align restart of all channels.
REQ-008 SHALL have port WrEn  input  1  divisor write request.
REQ-009 SHALL have port WrCh  input  max(1,clog2(NUM_CH))  target channel of write.
REQ-010 SHALL have port WrHalf  input  CNT_W  new half-period value.
REQ-011 SHALL have port WrRdy  output  1  write slot free; write accepted when WrEn and WrRdy both high.
REQ-012 SHALL have port ClkOut  output  NUM_CH  divided clocks, registered.
REQ-013 SHALL have port Tick  output  NUM_CH  one-cycle pulse, registered, coincident with each ClkOut rising edge.

Function
REQ-014 SHALL keep per channel i a counter Cnt[i] and active half-period Half[i]; Half[i]=H>=1 gives ClkOut[i] period 2H Clk cycles, 50% duty.
REQ-015 SHALL, with En[i]=1 and H>=1, count Cnt[i] 0..H-1; at Cnt[i]==H-1 reset Cnt[i] to 0 and toggle ClkOut[i] on the same edge.
REQ-016 SHALL assert Tick[i] for exactly the cycle in which ClkOut[i] is first high after a 0->1 toggle; Tick[i]=0 otherwise.
REQ-017 SHALL, with En[i]=0, freeze Cnt[i] and ClkOut[i] at current values; Tick[i]=0; counting resumes from frozen Cnt[i] when En[i] returns high.
REQ-018 SHALL treat H=0 as channel off: Cnt[i]=0, ClkOut[i]=0, Tick[i]=0 regardless of En[i].
REQ-019 SHALL hold one shared pending-write slot (channel, value); WrRdy=0 while slot occupied, 1 otherwise.
REQ-020 SHALL ignore WrEn when WrRdy=0 or WrCh>=NUM_CH (no state change, WrRdy stays as is).
REQ-021 SHALL apply a pending write to Half[ch] glitch-free: on the edge where ClkOut[ch] toggles 1->0, simultaneously Cnt[ch]<=0; slot frees (WrRdy=1) the following cycle.
REQ-022 SHALL apply a pending write on the next edge if target channel has En=0 or current Half=0; Cnt[ch]<=0, ClkOut[ch]<=0.
REQ-023 SHALL, on Sync=1, set all Cnt to 0, all ClkOut to 0, all Tick to 0 on that edge, and apply any pending write immediately.
REQ-024 SHALL, on Sync=1 together with an accepted write, load WrHalf into Half[WrCh] on that edge; WrRdy stays 1.
REQ-025 SHALL give Rst_n priority over Sync, WrEn and En.
REQ-026 SHALL perform no arithmetic wider than CNT_W; compare Cnt against Half-1 without wrap (H>=1 guaranteed by REQ-018).

Reset
REQ-027 SHALL, on Clk edge with Rst_n=0: Cnt=0, Half=DEF_HALF for all channels, ClkOut=0, Tick=0, slot empty, WrRdy=1.
REQ-028 SHALL discard any pending write when reset asserts mid-operation.

Verification
REQ-029 SHALL cover: NUM_CH=2, DEF_HALF=3, En=2'b11 after reset -> ClkOut both toggle every 3 cycles, period 6, first rise 3 cycles after En, Tick high 1 cycle per rise.
REQ-030 SHALL cover: ch0 H=3 running high, write ch0 WrHalf=5 -> WrRdy low, Half changes only at next 1->0 toggle, then period 10, no pulse shorter than 3 cycles.
REQ-031 SHALL cover: En[1] dropped mid-count at Cnt=1 for 4 cycles -> ClkOut[1] and Cnt frozen, resumes reaching toggle 2 cycles after En re-asserted.
REQ-032 SHALL cover: write WrHalf=0 to ch1 -> ClkOut[1]=0, Tick[1]=0 permanently; subsequent write WrHalf=2 applied next cycle, period 4.
REQ-033 SHALL cover: Sync pulse with ch0 and ch1 at differing phases -> both ClkOut 0 next cycle, thereafter identical-phase waveforms for equal H; Sync+WrEn same cycle loads value immediately.
REQ-034 SHALL cover: Rst_n low mid-period with write pending -> all outputs 0, WrRdy=1, Half=DEF_HALF after one edge.
